// File: rtl/door_lock_ctrl.sv
// Passcode sequencer: collects PW_LEN keypad digits, checks them against the stored
// password, drives the open/error/lockout windows. Optional macro: DOOR_LOCK_PW_CHANGE_EN.
module door_lock_ctrl #(
    parameter int          PW_LEN         = 4,
    parameter logic [31:0] DEFAULT_PW     = 32'h0000_1234,
    parameter int          UNLOCK_CYCLES  = 100,
    parameter int          ERR_CYCLES     = 20,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 200,
    parameter int          ENTRY_TIMEOUT  = 150
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       key_pulse,
    input  logic [3:0] key_value,
    output logic       door_open,
    output logic       err_flag,
    output logic       alarm,
    output logic [3:0] digit_count,
    output logic [3:0] fail_count,
    output logic       pw_updated,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_ERROR   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam int TM1  = (UNLOCK_CYCLES > ERR_CYCLES) ? UNLOCK_CYCLES : ERR_CYCLES;
    localparam int TM2  = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(PW_LEN);

    // Timers are loaded with N-1 and the state is left when they read zero: N cycles.
    localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_ERR    = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ENTRY  = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [3:0]    LAST     = 4'(PW_LEN - 1);
    localparam logic [3:0]    MAXF     = 4'(MAX_FAIL);
    localparam logic [4*PW_LEN-1:0] PW_RST = DEFAULT_PW[4*PW_LEN-1:0];

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [3:0]               fail_q, fail_d;
    logic [TW-1:0]            tmr_q, tmr_d;
    logic [PW_LEN-1:0][3:0]   buf_q, buf_d;
    logic [PW_LEN-1:0][3:0]   pw;
    logic                     key_ok;
    logic                     expire;
    logic [3:0]               slot;
    logic [3:0]               fail_inc;

    assign key_ok   = key_pulse && (key_value >= 4'd1) && (key_value <= 4'd9);
    assign fail_inc = fail_q + 4'd1;

`ifdef DOOR_LOCK_PW_CHANGE_EN
    logic [PW_LEN-1:0][3:0] pw_q, pw_d;
    logic                   upd_q, upd_d;
    assign pw         = pw_q;
    assign pw_updated = upd_q;
`else
    assign pw         = PW_RST;
    assign pw_updated = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        buf_d   = buf_q;
        expire  = 1'b0;
        slot    = cnt_q;
`ifdef DOOR_LOCK_PW_CHANGE_EN
        pw_d    = pw_q;
        upd_d   = 1'b0;
`endif
        case (state_q)
            S_ENTRY: begin
                expire = (cnt_q != 4'd0) && (tmr_q == '0);
                if (key_ok) begin
                    // A key landing on the expiry cycle starts a fresh entry.
                    if (expire) begin
                        buf_d = '0;
                        slot  = 4'd0;
                    end
                    buf_d[slot[IW-1:0]] = key_value;
                    cnt_d = slot + 4'd1;
                    tmr_d = T_ENTRY;
                    if (slot == LAST) state_d = S_CHECK;
                end else if (expire) begin
                    buf_d = '0;
                    cnt_d = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d = 4'd0;
                buf_d = '0;
                if (buf_q == pw) begin
                    fail_d  = 4'd0;
                    state_d = S_OPEN;
                    tmr_d   = T_UNLOCK;
                end else if (fail_inc >= MAXF) begin
                    fail_d  = MAXF;
                    state_d = S_LOCKOUT;
                    tmr_d   = T_LOCK;
                end else begin
                    fail_d  = fail_inc;
                    state_d = S_ERROR;
                    tmr_d   = T_ERR;
                end
            end
            S_OPEN: begin
`ifdef DOOR_LOCK_PW_CHANGE_EN
                if (key_ok) begin
                    buf_d[cnt_q[IW-1:0]] = key_value;
                    tmr_d = T_UNLOCK;
                    if (cnt_q == LAST) begin
                        pw_d  = buf_d;
                        upd_d = 1'b1;
                        cnt_d = 4'd0;
                        buf_d = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else
`endif
                if (tmr_q == '0) begin
                    state_d = S_ENTRY;
                    cnt_d   = 4'd0;
                    buf_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_ERROR: begin
                if (tmr_q == '0) state_d = S_ENTRY;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d = S_ENTRY;
                    fail_d  = 4'd0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = S_ENTRY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_ENTRY;
            cnt_q   <= 4'd0;
            fail_q  <= 4'd0;
            tmr_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            tmr_q   <= tmr_d;
            buf_q   <= buf_d;
        end
    end

`ifdef DOOR_LOCK_PW_CHANGE_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pw_q  <= PW_RST;
            upd_q <= 1'b0;
        end else begin
            pw_q  <= pw_d;
            upd_q <= upd_d;
        end
    end
`endif

    assign door_open   = (state_q == S_OPEN);
    assign err_flag    = (state_q == S_ERROR);
    assign alarm       = (state_q == S_LOCKOUT);
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: directed scenarios plus random keys, every cycle compared
// against a queue/countdown model of the lock behaviour.
module tb_door_lock_ctrl;
    localparam int PW_LEN  = 4;
    localparam int UNLOCK  = 100;
    localparam int ERRC    = 20;
    localparam int MAXF    = 3;
    localparam int LOCKC   = 200;
    localparam int TOUT    = 150;
    // First digit entered sits in the low nibble, so the code 1-2-3-4 is 32'h4321.
    localparam logic [31:0] TB_PW = 32'h0000_4321;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       key_pulse = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       door_open, err_flag, alarm, pw_updated;
    logic [3:0] digit_count, fail_count;
    logic [2:0] state_o;

    door_lock_ctrl #(
        .PW_LEN(PW_LEN), .DEFAULT_PW(TB_PW), .UNLOCK_CYCLES(UNLOCK), .ERR_CYCLES(ERRC),
        .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LOCKC), .ENTRY_TIMEOUT(TOUT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .key_pulse(key_pulse), .key_value(key_value),
        .door_open(door_open), .err_flag(err_flag), .alarm(alarm),
        .digit_count(digit_count), .fail_count(fail_count),
        .pw_updated(pw_updated), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: spec state codes, queue of captured digits, cycles left in the timed phase.
    int m_st = 0;
    int m_left = 0;
    int m_fail = 0;
    int m_upd = 0;
    int dq[$];
    int mpw[PW_LEN];
    longint edge_n = 0;
    longint last_key = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("door_open",   int'(door_open),   int'(m_st == 2));
        chk("err_flag",    int'(err_flag),    int'(m_st == 3));
        chk("alarm",       int'(alarm),       int'(m_st == 4));
        chk("digit_count", int'(digit_count), dq.size());
        chk("fail_count",  int'(fail_count),  m_fail);
        chk("pw_updated",  int'(pw_updated),  m_upd);
        chk("state_o",     int'(state_o),     m_st);
    endtask

    task automatic model_step(input bit rn, input bit kp, input logic [3:0] kv);
        bit valid;
        bit ok;
        bit reload;
        valid  = kp && (kv >= 4'd1) && (kv <= 4'd9);
        reload = 0;
        m_upd  = 0;
        edge_n++;
        if (!rn) begin
            m_st = 0; m_left = 0; m_fail = 0; dq.delete();
            for (int i = 0; i < PW_LEN; i++) mpw[i] = int'((TB_PW >> (4*i)) & 32'hF);
            return;
        end
        case (m_st)
            0: begin
                if (dq.size() > 0 && (edge_n - last_key) >= TOUT) dq.delete();
                if (valid) begin
                    dq.push_back(int'(kv));
                    last_key = edge_n;
                    if (dq.size() == PW_LEN) m_st = 1;
                end
            end
            1: begin
                ok = 1;
                for (int i = 0; i < PW_LEN; i++) if (dq[i] != mpw[i]) ok = 0;
                dq.delete();
                if (ok) begin
                    m_fail = 0; m_st = 2; m_left = UNLOCK;
                end else begin
                    m_fail++;
                    if (m_fail >= MAXF) begin
                        m_fail = MAXF; m_st = 4; m_left = LOCKC;
                    end else begin
                        m_st = 3; m_left = ERRC;
                    end
                end
            end
            default: begin
`ifdef DOOR_LOCK_PW_CHANGE_EN
                if (m_st == 2 && valid) begin
                    reload = 1;
                    m_left = UNLOCK;
                    dq.push_back(int'(kv));
                    if (dq.size() == PW_LEN) begin
                        for (int i = 0; i < PW_LEN; i++) mpw[i] = dq[i];
                        m_upd = 1;
                        dq.delete();
                    end
                end
`endif
                if (!reload) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_st == 4) m_fail = 0;
                        m_st = 0;
                        dq.delete();
                    end
                end
            end
        endcase
    endtask

    // One clock: compare on the falling edge, drive, then advance the model on the rising edge.
    task automatic cyc(input bit rn, input bit kp, input logic [3:0] kv);
        @(negedge CLK);
        if (chk_en) check_outputs();
        #1;
        RESET = rn; key_pulse = kp; key_value = kv;
        @(posedge CLK);
        model_step(rn, kp, kv);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 4'd0);
    endtask

    task automatic key(input int d);
        cyc(1, 1, 4'(d));
    endtask

    // Four keys, one pulse every 5 clocks; returns right after the last key's edge.
    task automatic code(input int a, input int b, input int c, input int d);
        key(a); idle(4); key(b); idle(4); key(c); idle(4); key(d);
    endtask

    initial begin
        logic [3:0] kv;
        int r;
        cyc(0, 0, 4'd0);
        cyc(0, 0, 4'd0);
        chk_en = 1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_fail", int'(fail_count), 0);
        chk("rst_door", int'(door_open), 0);

        // Correct code: open two clocks after the last pulse, for UNLOCK clocks
        code(1, 2, 3, 4);
        chk("t1_check_state", int'(state_o), 1);
        chk("t1_door_lat1", int'(door_open), 0);
        idle(1);
        chk("t1_door_lat2", int'(door_open), 1);
        chk("t1_fail", int'(fail_count), 0);
        idle(99);
        chk("t1_door_last", int'(door_open), 1);
        idle(1);
        chk("t1_door_end", int'(door_open), 0);

        // Wrong code then right code
        code(1, 2, 3, 5);
        idle(1);
        chk("t2_err", int'(err_flag), 1);
        chk("t2_fail", int'(fail_count), 1);
        chk("t2_door", int'(door_open), 0);
        idle(19);
        chk("t2_err_last", int'(err_flag), 1);
        idle(1);
        chk("t2_err_end", int'(err_flag), 0);
        code(1, 2, 3, 4);
        idle(1);
        chk("t2_open", int'(door_open), 1);
        chk("t2_fail_clr", int'(fail_count), 0);
        idle(100);

        // Three failures -> lockout, keys ignored while alarmed
        for (int i = 0; i < 2; i++) begin
            code(1, 2, 3, 5);
            idle(21);
        end
        code(1, 2, 3, 6);
        idle(1);
        chk("t3_alarm", int'(alarm), 1);
        chk("t3_fail", int'(fail_count), 3);
        key(1); idle(4); key(2);
        chk("t3_keys_ignored", int'(digit_count), 0);
        idle(193);
        chk("t3_alarm_last", int'(alarm), 1);
        idle(1);
        chk("t3_alarm_end", int'(alarm), 0);
        chk("t3_fail_clr", int'(fail_count), 0);
        code(1, 2, 3, 4);
        idle(1);
        chk("t3_open", int'(door_open), 1);
        idle(100);

        // Entry timeout discards stale digits; invalid key codes ignored
        key(1); idle(4); key(2);
        idle(149);
        chk("t4_cnt_before_to", int'(digit_count), 2);
        idle(1);
        chk("t4_cnt_after_to", int'(digit_count), 0);
        code(3, 4, 1, 2);
        idle(1);
        chk("t4_err", int'(err_flag), 1);
        idle(20);
        key(1); idle(4);
        cyc(1, 1, 4'd0);
        chk("t4_key0_ignored", int'(digit_count), 1);
        cyc(1, 1, 4'd12);
        chk("t4_key12_ignored", int'(digit_count), 1);
        key(2);
        chk("t4_cnt2", int'(digit_count), 2);
        idle(4); key(3); idle(4); key(4);
        idle(1);
        chk("t4_open", int'(door_open), 1);
        idle(100);
        // Key on the exact expiry cycle restarts the entry as digit 0
        key(5);
        idle(149);
        key(6);
        chk("t4_key_wins", int'(digit_count), 1);
        idle(151);
        chk("t4_key_wins_to", int'(digit_count), 0);

`ifdef DOOR_LOCK_PW_CHANGE_EN
        code(1, 2, 3, 4);
        idle(1);
        chk("t5_open", int'(door_open), 1);
        idle(5);
        code(9, 8, 7, 6);
        chk("t5_upd", int'(pw_updated), 1);
        chk("t5_cnt_clr", int'(digit_count), 0);
        chk("t5_still_open", int'(door_open), 1);
        idle(1);
        chk("t5_upd_once", int'(pw_updated), 0);
        idle(99);
        chk("t5_closed", int'(door_open), 0);
        code(1, 2, 3, 4);
        idle(1);
        chk("t5_old_pw_err", int'(err_flag), 1);
        idle(20);
        code(9, 8, 7, 6);
        idle(1);
        chk("t5_new_pw_open", int'(door_open), 1);
        idle(100);
`endif

        // Reset mid-OPEN and mid-LOCKOUT
        code(mpw[0], mpw[1], mpw[2], mpw[3]);
        idle(10);
        cyc(0, 0, 4'd0);
        chk("t6_rst_door", int'(door_open), 0);
        chk("t6_rst_state", int'(state_o), 0);
        chk("t6_rst_upd", int'(pw_updated), 0);
        code(1, 2, 3, 4);
        idle(1);
        chk("t6_pw_restored", int'(door_open), 1);
        idle(100);
        for (int i = 0; i < 3; i++) begin
            code(1, 2, 3, 7);
            idle(21);
        end
        idle(30);
        cyc(0, 0, 4'd0);
        chk("t6_rst_alarm", int'(alarm), 0);
        chk("t6_rst_fail", int'(fail_count), 0);
        chk("t6_rst_state2", int'(state_o), 0);
        code(1, 2, 3, 4);
        idle(1);
        chk("t6_open_after_rst", int'(door_open), 1);
        idle(100);

        // Random keys, biased toward the current password, occasional resets and long gaps
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                cyc(0, 0, 4'd0);
            end else if (r < 5) begin
                idle(160);
            end else if (r < 250) begin
                if (r < 160) kv = 4'(mpw[dq.size() % PW_LEN]);
                else         kv = 4'($urandom_range(0, 15));
                cyc(1, 1, kv);
            end else begin
                cyc(1, 0, 4'($urandom_range(0, 15)));
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
